rx_oversample_counter: RTL and testbench

// - Parametrised oversampling tick/bit counter for the UART receive path; successor to the fixed 16x tick counter.
// - Counts RX_tick strobes per bit (runtime prescale), emits mid-bit sample strobe, bit-done and frame-done pulses.
// - Captures RX_IN at mid-bit (optionally 3-sample majority); sits between the baud tick generator and the RX FSM.

---
 rtl/rx_oversample_counter_if.sv | 29 ++
 rtl/rx_oversample_counter.sv | 190 +++++++++++++++++++
 tb/tb_rx_oversample_counter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_oversample_counter_if.sv
// Signal bundle between the baud tick generator / RX FSM side (master)
// and the oversampling tick/bit counter (slave).
interface rx_oversample_counter_if #(
  parameter int CNT_W = 6,
  parameter int BIT_W = 4
);
  logic             RX_tick;
  logic             TICK_COUNT_EN;
  logic             RX_IN;
  logic [CNT_W-1:0] PRESCALE;
  logic [BIT_W-1:0] FRAME_LEN;
  logic             SAMPLE_EN;
  logic             SAMPLED_BIT;
  logic             BIT_DONE;
  logic             FRAME_DONE;
  logic [CNT_W-1:0] TICK_CNT;
  logic [BIT_W-1:0] BIT_CNT;
  logic             BUSY;

  modport master (
    output RX_tick, TICK_COUNT_EN, RX_IN, PRESCALE, FRAME_LEN,
    input  SAMPLE_EN, SAMPLED_BIT, BIT_DONE, FRAME_DONE, TICK_CNT, BIT_CNT, BUSY
  );

  modport slave (
    input  RX_tick, TICK_COUNT_EN, RX_IN, PRESCALE, FRAME_LEN,
    output SAMPLE_EN, SAMPLED_BIT, BIT_DONE, FRAME_DONE, TICK_CNT, BIT_CNT, BUSY
  );
endinterface

// File: rtl/rx_oversample_counter.sv
// Oversampling tick/bit counter for the UART receive path.
// Counts RX_tick strobes per bit with a runtime prescale latched at start,
// emits registered mid-bit sample, bit-done and frame-done pulses.
// Optional build macro MAJORITY_VOTE_EN: 3-sample majority around mid-bit
// instead of a single mid-bit capture.
module rx_oversample_counter #(
  parameter int CNT_W = 6,
  parameter int BIT_W = 4
) (
  input logic                   CLK,
  input logic                   RST,
  rx_oversample_counter_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(4);
  localparam logic [BIT_W-1:0] B_ONE = BIT_W'(1);

  // Prescale below 4 would put the sample window outside the bit.
  function automatic logic [CNT_W-1:0] clamp_prescale(input logic [CNT_W-1:0] p);
    return (p < P_MIN) ? P_MIN : p;
  endfunction

  // A zero-length frame is treated as a single-bit frame.
  function automatic logic [BIT_W-1:0] clamp_frame(input logic [BIT_W-1:0] f);
    return (f == '0) ? B_ONE : f;
  endfunction

`ifdef MAJORITY_VOTE_EN
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] prescale_q, prescale_d;
  logic [BIT_W-1:0] frame_len_q, frame_len_d;
  logic             sample_en_q, sample_en_d;
  logic             sampled_bit_q, sampled_bit_d;
  logic             bit_done_q, bit_done_d;
  logic             frame_done_q, frame_done_d;
`ifdef MAJORITY_VOTE_EN
  logic [1:0]       vote_q, vote_d;
  logic [CNT_W-1:0] mid_m1, mid_p1;
`endif

  // Working values for the tick being processed this cycle.
  logic [CNT_W-1:0] p_eff;
  logic [BIT_W-1:0] fl_eff;
  logic [CNT_W-1:0] idx;
  logic [BIT_W-1:0] bidx;
  logic [CNT_W-1:0] mid;
  logic             do_tick;

  // Next-state logic: IDLE/RUN control, tick/bit counting and pulse generation.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    prescale_d    = prescale_q;
    frame_len_d   = frame_len_q;
    sample_en_d   = 1'b0;
    sampled_bit_d = sampled_bit_q;
    bit_done_d    = 1'b0;
    frame_done_d  = 1'b0;
`ifdef MAJORITY_VOTE_EN
    vote_d        = vote_q;
`endif
    p_eff   = prescale_q;
    fl_eff  = frame_len_q;
    idx     = tick_cnt_q;
    bidx    = bit_cnt_q;
    do_tick = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.TICK_COUNT_EN) begin
          // Config used by a tick arriving in the same cycle is the freshly latched one.
          state_d     = S_RUN;
          prescale_d  = clamp_prescale(bus.PRESCALE);
          frame_len_d = clamp_frame(bus.FRAME_LEN);
          p_eff       = prescale_d;
          fl_eff      = frame_len_d;
          idx         = '0;
          bidx        = '0;
          do_tick     = bus.RX_tick;
        end
      end
      S_RUN: begin
        if (!bus.TICK_COUNT_EN) begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
`ifdef MAJORITY_VOTE_EN
          vote_d     = '0;
`endif
        end else begin
          do_tick = bus.RX_tick;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mid = (p_eff >> 1) - C_ONE;
`ifdef MAJORITY_VOTE_EN
    mid_m1 = mid - C_ONE;
    mid_p1 = mid + C_ONE;
`endif

    if (do_tick) begin
      if (idx == p_eff - C_ONE) begin
        tick_cnt_d = '0;
        bit_done_d = 1'b1;
`ifdef MAJORITY_VOTE_EN
        vote_d     = '0;
`endif
        if (bidx == fl_eff - B_ONE) begin
          bit_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          bit_cnt_d = bidx + B_ONE;
        end
      end else begin
        tick_cnt_d = idx + C_ONE;
      end

`ifdef MAJORITY_VOTE_EN
      // Window start restarts the capture history, so stale bits never vote.
      if (idx == mid_m1) begin
        vote_d = {1'b0, bus.RX_IN};
      end else if (idx == mid) begin
        vote_d = {vote_q[0], bus.RX_IN};
      end else if (idx == mid_p1) begin
        sampled_bit_d = majority3(vote_q[1], vote_q[0], bus.RX_IN);
        sample_en_d   = 1'b1;
        vote_d        = '0;
      end
`else
      if (idx == mid) begin
        sampled_bit_d = bus.RX_IN;
        sample_en_d   = 1'b1;
      end
`endif
    end
  end

  // State, counter, latched config and registered pulse flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      prescale_q    <= '0;
      frame_len_q   <= '0;
      sample_en_q   <= 1'b0;
      sampled_bit_q <= 1'b0;
      bit_done_q    <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef MAJORITY_VOTE_EN
      vote_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      prescale_q    <= prescale_d;
      frame_len_q   <= frame_len_d;
      sample_en_q   <= sample_en_d;
      sampled_bit_q <= sampled_bit_d;
      bit_done_q    <= bit_done_d;
      frame_done_q  <= frame_done_d;
`ifdef MAJORITY_VOTE_EN
      vote_q        <= vote_d;
`endif
    end
  end

  assign bus.SAMPLE_EN   = sample_en_q;
  assign bus.SAMPLED_BIT = sampled_bit_q;
  assign bus.BIT_DONE    = bit_done_q;
  assign bus.FRAME_DONE  = frame_done_q;
  assign bus.TICK_CNT    = tick_cnt_q;
  assign bus.BIT_CNT     = bit_cnt_q;
  assign bus.BUSY        = (state_q == S_RUN);

endmodule

// File: tb/tb_rx_oversample_counter.sv
// Scoreboard bench for rx_oversample_counter: a driver issues one input
// vector per clock and pushes the reference model's expected outputs; a
// monitor pops and compares after every clock edge.
module tb_rx_oversample_counter;

  logic clk;
  logic rst_n;

  rx_oversample_counter_if #(.CNT_W(6), .BIT_W(4)) bus ();

  rx_oversample_counter #(.CNT_W(6), .BIT_W(4)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [5:0] tc;
    logic [3:0] bc;
    logic       se;
    logic       sb;
    logic       bd;
    logic       fd;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: ticks counted since the run started.
  bit   m_run = 0;
  int   m_n   = 0;
  int   m_p   = 4;
  int   m_fl  = 1;
  logic m_sampled = 1'b0;
  logic hist [64];

  logic [5:0] cur_pre = '0;
  logic [3:0] cur_fl  = '0;

  function automatic int tick_index();
    return m_run ? (m_n % m_p) : 0;
  endfunction

  // One clock of stimulus; the model predicts the state after the next edge.
  task automatic step(input logic tk, input logic en, input logic rx);
    exp_t e;
    int   idx, bitn, mid;
    @(negedge clk);
    bus.RX_tick       = tk;
    bus.TICK_COUNT_EN = en;
    bus.RX_IN         = rx;
    bus.PRESCALE      = cur_pre;
    bus.FRAME_LEN     = cur_fl;
    e = '0;
    if (!m_run && en) begin
      m_run = 1;
      m_n   = 0;
      m_p   = (int'(cur_pre) < 4) ? 4 : int'(cur_pre);
      m_fl  = (cur_fl == 0) ? 1 : int'(cur_fl);
    end else if (m_run && !en) begin
      m_run = 0;
      m_n   = 0;
    end else if (m_run && tk) begin
      // handled below
    end
    if (m_run && en && tk) begin
      idx  = m_n % m_p;
      bitn = (m_n / m_p) % m_fl;
      mid  = m_p / 2 - 1;
      hist[idx] = rx;
`ifdef MAJORITY_VOTE_EN
      if (idx == mid + 1) begin
        e.se = 1'b1;
        m_sampled = ((int'(hist[mid-1]) + int'(hist[mid]) + int'(rx)) >= 2);
      end
`else
      if (idx == mid) begin
        e.se = 1'b1;
        m_sampled = rx;
      end
`endif
      e.bd = (idx == m_p - 1);
      e.fd = (idx == m_p - 1) && (bitn == m_fl - 1);
      m_n++;
    end
    e.busy = m_run;
    e.tc   = m_run ? 6'(m_n % m_p) : 6'd0;
    e.bc   = m_run ? 4'((m_n / m_p) % m_fl) : 4'd0;
    e.sb   = m_sampled;
    expq.push_back(e);
  endtask

  // Issue n ticks spaced by gap clocks; rx pattern chosen from the tick index.
  task automatic run_ticks(input int n, input int gap, input int mode);
    int   idx;
    logic rx;
    for (int k = 0; k < n; k++) begin
      idx = tick_index();
      case (mode)
        0:       rx = 1'b1;
        2:       rx = (idx == 7) ? 1'b0 : 1'b1;
        3:       rx = (idx == 6 || idx == 7) ? 1'b0 : 1'b1;
        default: rx = 1'($urandom_range(0, 1));
      endcase
      step(1'b1, 1'b1, rx);
      for (int g = 1; g < gap; g++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check1(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, " BUSY"},        int'(bus.BUSY),        0);
    check1({tag, " TICK_CNT"},    int'(bus.TICK_CNT),    0);
    check1({tag, " BIT_CNT"},     int'(bus.BIT_CNT),     0);
    check1({tag, " SAMPLE_EN"},   int'(bus.SAMPLE_EN),   0);
    check1({tag, " SAMPLED_BIT"}, int'(bus.SAMPLED_BIT), 0);
    check1({tag, " BIT_DONE"},    int'(bus.BIT_DONE),    0);
    check1({tag, " FRAME_DONE"},  int'(bus.FRAME_DONE),  0);
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.busy = bus.BUSY;
        a.tc   = bus.TICK_CNT;
        a.bc   = bus.BIT_CNT;
        a.se   = bus.SAMPLE_EN;
        a.sb   = bus.SAMPLED_BIT;
        a.bd   = bus.BIT_DONE;
        a.fd   = bus.FRAME_DONE;
        total++;
        if (a != e) begin
          bad++;
          $display("FAIL status @%0t: got busy=%0d tick=%0d bit=%0d se=%0d sb=%0d bd=%0d fd=%0d expected busy=%0d tick=%0d bit=%0d se=%0d sb=%0d bd=%0d fd=%0d",
                   $time, a.busy, a.tc, a.bc, a.se, a.sb, a.bd, a.fd,
                   e.busy, e.tc, e.bc, e.se, e.sb, e.bd, e.fd);
        end
      end
    end
  end

  initial begin
    rst_n             = 1'b0;
    bus.RX_tick       = 1'b0;
    bus.TICK_COUNT_EN = 1'b0;
    bus.RX_IN         = 1'b1;
    bus.PRESCALE      = '0;
    bus.FRAME_LEN     = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle without enable: nothing moves.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);

    // P=16, 10-bit frame, tick every 4 clocks, line high.
    cur_pre = 6'd16; cur_fl = 4'd10;
    run_ticks(165, 4, 0);
    step(1'b0, 1'b0, 1'b1);

    // Prescale 3 clamps to 4; short frames back to back.
    cur_pre = 6'd3; cur_fl = 4'd2;
    run_ticks(30, 2, 1);
    step(1'b0, 1'b0, 1'b1);

    // Glitch patterns around mid-bit.
    cur_pre = 6'd16; cur_fl = 4'd2;
    run_ticks(32, 1, 2);
    run_ticks(32, 1, 3);
    step(1'b0, 1'b0, 1'b1);

    // Enable drop at tick 12 of bit 3, then restart with prescale 8.
    cur_pre = 6'd16; cur_fl = 4'd10;
    run_ticks(3 * 16 + 12, 1, 1);
    step(1'b1, 1'b0, 1'b0);
    cur_pre = 6'd8;
    run_ticks(20, 1, 1);
    step(1'b0, 1'b0, 1'b1);

    // Config changes during RUN must be ignored.
    cur_pre = 6'd16; cur_fl = 4'd3;
    step(1'b1, 1'b1, 1'b1);
    cur_pre = 6'd8; cur_fl = 4'd0;
    run_ticks(40, 2, 1);
    step(1'b0, 1'b0, 1'b1);

    // Randomised traffic: random config, tick density, line and enable drops.
    for (int i = 0; i < 3000; i++) begin
      logic en;
      cur_pre = 6'($urandom_range(0, 63));
      cur_fl  = 4'($urandom_range(0, 15));
      if (m_run) en = ($urandom_range(0, 199) != 0);
      else       en = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 2) == 0), en, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a bit.
    cur_pre = 6'd16; cur_fl = 4'd10;
    run_ticks(9, 2, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.TICK_COUNT_EN = 1'b0;
    #1;
    check_all_zero("async reset");
    m_run = 0; m_n = 0; m_sampled = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    run_ticks(20, 1, 1);

    @(posedge clk);
    @(posedge clk);
    #2;
    check1("scoreboard drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
